// File: rtl/eth_mmio_tracker.sv
// MMIO request tracker: forwards register requests to the Ethernet core as one-cycle strobes
// and returns read data / write acks in order through a credit-limited response FIFO.
module eth_mmio_tracker #(
    parameter int addr_width_p  = 32,
    parameter int data_width_p  = 32,
    parameter int outstanding_p = 4,
    parameter int resp_els_p    = 4,
    parameter int sync_stages_p = 4,
    parameter int irq_sources_p = 2
) (
    input  logic                                   clk250_i,
    input  logic                                   reset_r_lo,
    output logic                                   reset_sync_o,
    input  logic                                   req_v_i,
    output logic                                   req_ready_and_o,
    input  logic [addr_width_p-1:0]                req_addr_i,
    input  logic                                   req_wr_en_i,
    input  logic [1:0]                             req_size_i,
    input  logic [data_width_p-1:0]                req_wdata_i,
    output logic [addr_width_p-1:0]                core_addr_o,
    output logic [1:0]                             core_size_o,
    output logic [data_width_p-1:0]                core_wdata_o,
    output logic                                   core_write_en_o,
    output logic                                   core_read_en_o,
    input  logic [data_width_p-1:0]                core_rdata_i,
    input  logic                                   core_rdata_v_i,
    output logic                                   resp_v_o,
    input  logic                                   resp_ready_and_i,
    output logic [data_width_p-1:0]                resp_data_o,
    output logic                                   resp_wr_o,
    output logic [$clog2(outstanding_p+1)-1:0]     outstanding_o,
    input  logic [irq_sources_p-1:0]               irq_pending_i,
    input  logic [irq_sources_p-1:0]               irq_en_i,
    output logic                                   irq_o,
    output logic                                   error_o
);

    localparam int              cnt_w_lp    = $clog2(outstanding_p + 1);
    localparam int              ptr_w_lp    = (resp_els_p > 1) ? $clog2(resp_els_p) : 1;
    localparam int              fcnt_w_lp   = $clog2(resp_els_p + 1);
    localparam int              bytes_lp    = data_width_p / 8;
    localparam logic [1:0]      max_size_lp = 2'($clog2(bytes_lp));

    if (resp_els_p < outstanding_p) begin : g_bad_depth
        $error("resp_els_p must be >= outstanding_p");
    end
    if (sync_stages_p < 2) begin : g_bad_sync
        $error("sync_stages_p must be >= 2");
    end

    // Reset synchroniser: asserts asynchronously, releases on the sync_stages_p-th clock.
    logic [sync_stages_p-1:0] sync_q;

    always_ff @(posedge clk250_i or posedge reset_r_lo) begin
        if (reset_r_lo) sync_q <= '1;
        else            sync_q <= {1'b0, sync_q[sync_stages_p-1:1]};
    end

    assign reset_sync_o = sync_q[0];

    logic rst_int;
    assign rst_int = reset_r_lo | sync_q[0];

    logic [cnt_w_lp-1:0]    cnt_q, cnt_d;
    logic                   accept, deq, enq, full, do_enq, err_d;
    logic                   pend_v_q, pend_wr_q;
    logic [1:0]             pend_size_q, size_clamped;
    logic [data_width_p-1:0] packed_data;
    logic [ptr_w_lp-1:0]    wptr_q, rptr_q;
    logic [fcnt_w_lp-1:0]   fcnt_q, fcnt_d;
    logic                   irq_q, err_q;
    logic [data_width_p:0]  mem_q [resp_els_p];

    assign req_ready_and_o = ~reset_sync_o & (cnt_q < cnt_w_lp'(outstanding_p));
    assign accept          = req_v_i & req_ready_and_o;
    assign deq             = resp_v_o & resp_ready_and_i;
    assign outstanding_o   = cnt_q;

    assign core_addr_o     = req_addr_i;
    assign core_size_o     = req_size_i;
    assign core_wdata_o    = req_wdata_i;
    assign core_write_en_o = accept & req_wr_en_i;
    assign core_read_en_o  = accept & ~req_wr_en_i;

    assign size_clamped = (req_size_i > max_size_lp) ? max_size_lp : req_size_i;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q;
        if (accept && !deq)      cnt_d = cnt_q + cnt_w_lp'(1);
        else if (!accept && deq) cnt_d = cnt_q - cnt_w_lp'(1);
    end

    // Replicate the low 2^size bytes of the read word across the whole response.
    always_comb begin
        packed_data = '0;
        for (int i = 0; i < bytes_lp; i++) begin
            packed_data[8*i +: 8] = core_rdata_i[8*(i % (1 << pend_size_q)) +: 8];
        end
    end

    assign enq    = pend_v_q;
    assign full   = (fcnt_q == fcnt_w_lp'(resp_els_p));
    assign do_enq = enq & (~full | deq);
    assign err_d  = (core_rdata_v_i != (pend_v_q & ~pend_wr_q)) | (enq & full & ~deq);

    always_comb begin
        fcnt_d = fcnt_q;
        if (do_enq && !deq)      fcnt_d = fcnt_q + fcnt_w_lp'(1);
        else if (!do_enq && deq) fcnt_d = fcnt_q - fcnt_w_lp'(1);
    end

    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(resp_els_p - 1)) ? '0 : p + ptr_w_lp'(1);
    endfunction

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk250_i or posedge rst_int) begin
        if (rst_int) begin
            cnt_q       <= '0;
            pend_v_q    <= 1'b0;
            pend_wr_q   <= 1'b0;
            pend_size_q <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            fcnt_q      <= '0;
            irq_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            pend_v_q    <= accept;
            pend_wr_q   <= req_wr_en_i;
            pend_size_q <= size_clamped;
            fcnt_q      <= fcnt_d;
            irq_q       <= |(irq_pending_i & irq_en_i);
            err_q       <= err_q | err_d;
            if (do_enq) wptr_q <= ptr_inc(wptr_q);
            if (deq)    rptr_q <= ptr_inc(rptr_q);
        end
    end

    // NOTE: the payload array has no reset; entries are only visible once the valid count covers them.
    always_ff @(posedge clk250_i) begin
        if (do_enq) mem_q[wptr_q] <= {pend_wr_q, pend_wr_q ? {data_width_p{1'b0}} : packed_data};
    end

    assign resp_v_o    = (fcnt_q != '0);
    assign resp_wr_o   = resp_v_o & mem_q[rptr_q][data_width_p];
    assign resp_data_o = resp_v_o ? mem_q[rptr_q][data_width_p-1:0] : '0;
    assign irq_o       = irq_q;
    assign error_o     = err_q;

endmodule

// File: tb/tb_eth_mmio_tracker.sv
// Scoreboard bench for eth_mmio_tracker: a driver pushes expected responses, a monitor pops and compares.
`timescale 1ns/1ps
module tb_eth_mmio_tracker;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int OUT  = 4;
    localparam int ELS  = 4;
    localparam int SYNC = 4;
    localparam int IRQ  = 2;

    logic          clk250_i = 1'b0;
    logic          reset_r_lo;
    logic          reset_sync_o;
    logic          req_v_i, req_ready_and_o;
    logic [AW-1:0] req_addr_i;
    logic          req_wr_en_i;
    logic [1:0]    req_size_i;
    logic [DW-1:0] req_wdata_i;
    logic [AW-1:0] core_addr_o;
    logic [1:0]    core_size_o;
    logic [DW-1:0] core_wdata_o;
    logic          core_write_en_o, core_read_en_o;
    logic [DW-1:0] core_rdata_i;
    logic          core_rdata_v_i;
    logic          resp_v_o, resp_ready_and_i;
    logic [DW-1:0] resp_data_o;
    logic          resp_wr_o;
    logic [$clog2(OUT+1)-1:0] outstanding_o;
    logic [IRQ-1:0] irq_pending_i, irq_en_i;
    logic          irq_o, error_o;

    eth_mmio_tracker #(
        .addr_width_p(AW), .data_width_p(DW), .outstanding_p(OUT),
        .resp_els_p(ELS), .sync_stages_p(SYNC), .irq_sources_p(IRQ)
    ) dut (
        .clk250_i(clk250_i), .reset_r_lo(reset_r_lo), .reset_sync_o(reset_sync_o),
        .req_v_i(req_v_i), .req_ready_and_o(req_ready_and_o), .req_addr_i(req_addr_i),
        .req_wr_en_i(req_wr_en_i), .req_size_i(req_size_i), .req_wdata_i(req_wdata_i),
        .core_addr_o(core_addr_o), .core_size_o(core_size_o), .core_wdata_o(core_wdata_o),
        .core_write_en_o(core_write_en_o), .core_read_en_o(core_read_en_o),
        .core_rdata_i(core_rdata_i), .core_rdata_v_i(core_rdata_v_i),
        .resp_v_o(resp_v_o), .resp_ready_and_i(resp_ready_and_i),
        .resp_data_o(resp_data_o), .resp_wr_o(resp_wr_o), .outstanding_o(outstanding_o),
        .irq_pending_i(irq_pending_i), .irq_en_i(irq_en_i), .irq_o(irq_o), .error_o(error_o)
    );

    always #5 clk250_i = ~clk250_i;

    typedef struct {
        bit            wr;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            model_cnt = 0;
    bit            exp_err, exp_irq, acc_now, inj_now, mon_en;
    bit            rd_pend;
    logic [DW-1:0] rd_pend_data;
    int            rrdy_mode;
    bit            irq_rand;
    logic [IRQ-1:0] irq_p_cfg, irq_e_cfg;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: take the low 2^size bytes (clamped to the bus) and tile them across the word.
    function automatic logic [DW-1:0] pack_model(input logic [DW-1:0] raw, input logic [1:0] size);
        longint unsigned nbytes, chunk, res;
        nbytes = 64'd1 << size;
        if (nbytes > DW / 8) nbytes = DW / 8;
        chunk = raw % (64'd1 << (8 * nbytes));
        res = 0;
        for (longint unsigned k = 0; k < (DW / 8) / nbytes; k++) res += chunk << (8 * nbytes * k);
        return res[DW-1:0];
    endfunction

    task automatic do_cycle(input bit v, input bit wr, input logic [1:0] size,
                            input logic [DW-1:0] rdata, input bit inject = 1'b0);
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        bit            acc;
        exp_t          e;
        addr  = $urandom;
        wdata = $urandom;
        @(negedge clk250_i);
        core_rdata_v_i   = rd_pend | inject;
        core_rdata_i     = rd_pend ? rd_pend_data : $urandom;
        inj_now          = inject;
        req_v_i          = v;
        req_wr_en_i      = wr;
        req_size_i       = size;
        req_addr_i       = addr;
        req_wdata_i      = wdata;
        resp_ready_and_i = (rrdy_mode == 2) ? ($urandom_range(0, 3) != 0) : (rrdy_mode == 1);
        if (irq_rand) begin
            irq_pending_i = IRQ'($urandom);
            irq_en_i      = IRQ'($urandom);
        end else begin
            irq_pending_i = irq_p_cfg;
            irq_en_i      = irq_e_cfg;
        end
        acc     = v && (model_cnt < OUT);
        acc_now = acc;
        if (acc) begin
            e.wr   = wr;
            e.data = wr ? '0 : pack_model(rdata, size);
            e.due  = cyc + 2;
            sb.push_back(e);
        end
        rd_pend      = acc && !wr;
        rd_pend_data = rdata;
        #1;
        check("wr_strobe", core_write_en_o, acc && wr);
        check("rd_strobe", core_read_en_o, acc && !wr);
        if (v) begin
            check("addr_pass", core_addr_o, addr);
            check("wdata_pass", core_wdata_o, wdata);
            check("size_pass", core_size_o, size);
        end
    endtask

    task automatic do_reset();
        @(negedge clk250_i);
        mon_en         = 1'b0;
        reset_r_lo     = 1'b1;
        req_v_i        = 1'b0;
        core_rdata_v_i = 1'b1;
        core_rdata_i   = $urandom;
        #1;
        check("rst_sync", reset_sync_o, 1);
        check("rst_ready", req_ready_and_o, 0);
        check("rst_wr_strobe", core_write_en_o, 0);
        check("rst_rd_strobe", core_read_en_o, 0);
        check("rst_resp_v", resp_v_o, 0);
        check("rst_resp_wr", resp_wr_o, 0);
        check("rst_resp_data", resp_data_o, 0);
        check("rst_outstanding", outstanding_o, 0);
        check("rst_irq", irq_o, 0);
        check("rst_error", error_o, 0);
        repeat (3) @(negedge clk250_i);
        reset_r_lo     = 1'b0;
        core_rdata_v_i = 1'b0;
        for (int k = 1; k <= SYNC; k++) begin
            @(posedge clk250_i);
            #1;
            check("sync_release", reset_sync_o, k < SYNC);
            check("ready_release", req_ready_and_o, k == SYNC);
            check("release_error", error_o, 0);
        end
        sb.delete();
        model_cnt = 0;
        exp_err   = 1'b0;
        exp_irq   = 1'b0;
        acc_now   = 1'b0;
        inj_now   = 1'b0;
        rd_pend   = 1'b0;
        mon_en    = 1'b1;
    endtask

    // Monitor: compares registered outputs mid-cycle, then folds this cycle's events into the model.
    initial begin
        forever begin
            @(negedge clk250_i);
            #2;
            if (mon_en) begin
                bit   fire, due_v;
                exp_t e;
                check("ready", req_ready_and_o, model_cnt < OUT);
                check("outstanding", outstanding_o, model_cnt);
                check("error", error_o, exp_err);
                check("irq", irq_o, exp_irq);
                due_v = (sb.size() > 0) && (sb[0].due <= cyc);
                check("resp_v", resp_v_o, due_v);
                fire = resp_v_o && resp_ready_and_i;
                if (fire) begin
                    if (sb.size() == 0) begin
                        check("unexpected_resp", resp_v_o, 0);
                    end else begin
                        e = sb.pop_front();
                        check("resp_wr", resp_wr_o, e.wr);
                        check("resp_data", resp_data_o, e.data);
                    end
                end else if (!resp_v_o) begin
                    check("idle_resp", {resp_wr_o, resp_data_o}, 0);
                end
                model_cnt = model_cnt + int'(acc_now) - int'(fire);
                if (inj_now) exp_err = 1'b1;
                exp_irq = |(irq_pending_i & irq_en_i);
                acc_now = 1'b0;
                inj_now = 1'b0;
                cyc++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_r_lo       = 1'b1;
        req_v_i          = 1'b0;
        req_addr_i       = '0;
        req_wr_en_i      = 1'b0;
        req_size_i       = '0;
        req_wdata_i      = '0;
        core_rdata_i     = '0;
        core_rdata_v_i   = 1'b0;
        resp_ready_and_i = 1'b0;
        irq_pending_i    = '0;
        irq_en_i         = '0;
        irq_p_cfg        = '0;
        irq_e_cfg        = '0;
        irq_rand         = 1'b0;
        rrdy_mode        = 1;
        mon_en           = 1'b0;
        do_reset();

        // Back-to-back reads with responses held, then refused requests under backpressure.
        rrdy_mode = 0;
        irq_p_cfg = 2'b10;
        irq_e_cfg = 2'b01;
        do_cycle(1, 0, 2, 32'h11);
        do_cycle(1, 0, 2, 32'h22);
        do_cycle(1, 0, 2, 32'h33);
        do_cycle(1, 0, 2, 32'h44);
        do_cycle(1, 0, 2, 32'h55);
        check("b2b_outstanding", outstanding_o, 4);
        check("b2b_ready", req_ready_and_o, 0);
        irq_e_cfg = 2'b11;
        repeat (4) do_cycle(1, 0, 2, $urandom);
        rrdy_mode = 1;
        repeat (6) do_cycle(1, 0, 2, $urandom);
        repeat (6) do_cycle(0, 0, 0, 0);
        irq_e_cfg = 2'b00;

        // Mixed order and narrow reads.
        do_cycle(1, 1, 2, 0);
        do_cycle(1, 0, 0, 32'hA1B2C3D4);
        do_cycle(1, 1, 2, 0);
        do_cycle(1, 0, 1, 32'h1234ABCD);
        repeat (4) do_cycle(0, 0, 0, 0);

        // Spurious read-valid sets a sticky error.
        do_cycle(0, 0, 0, 0, 1'b1);
        repeat (3) do_cycle(0, 0, 0, 0);
        check("err_sticky", error_o, 1);

        // Reset with three responses queued.
        rrdy_mode = 0;
        repeat (3) do_cycle(1, 1, 2, 0);
        repeat (3) do_cycle(0, 0, 0, 0);
        check("queued_before_reset", resp_v_o, 1);
        do_reset();

        // Randomised traffic with random backpressure and interrupts.
        irq_rand  = 1'b1;
        rrdy_mode = 2;
        repeat (400) do_cycle($urandom_range(0, 9) < 7, 1'($urandom), 2'($urandom), $urandom);
        irq_rand  = 1'b0;
        rrdy_mode = 1;
        repeat (10) do_cycle(0, 0, 0, 0);
        check("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
